pipe_stall_flush_ctrl: RTL and testbench

Parametrised pipeline control unit for the 5-stage core. It is the successor to the current always-zero CTRL block. It resolves per-stage stall requests into the stage-hold vector, runs a multi-cycle flush/redirect sequence for exceptions and branch recovery, and keeps a stall watchdog and a stall performance counter. It sits beside the IF/ID/EX/MEM/WB stages and drives their common stall input.

---
 rtl/pipe_stall_flush_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipe_stall_flush_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_flush_ctrl.sv
// pipe_stall_flush_ctrl: pipeline hold/flush control for the 5-stage core.
// Resolves stall requests, sequences flush/redirect, watchdog, stall counter.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   stallreq      per-stage hold requests (bit 0 = PC, 1..5 = IF..WB)
//   ext_hold      memory-side hold, freezes the whole pipe
//   flush_req     one-cycle pulse starting a flush/redirect sequence
//   flush_pc      redirect target, sampled with flush_req
//   stall         stage-hold vector (1 = stage keeps its contents)
//   flush         clear all stage registers to bubble
//   new_pc_valid  one-cycle strobe, IF loads new_pc
//   new_pc        registered redirect target
//   stall_cause   highest requesting stage of the last stalled cycle
//   stall_cycles  saturating count of cycles with stall[0]=1
//   wdog_err      sticky, consecutive-stall limit reached

module pipe_stall_flush_ctrl #(
   parameter int                NSTAGE     = 6,
   parameter int                PC_W       = 32,
   parameter int                FLUSH_HOLD = 2,
   parameter int                WDOG_W     = 16,
   parameter logic [WDOG_W-1:0] WDOG_MAX   = 16'hFFFF,
   parameter int                PERF_W     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NSTAGE-1:0]         stallreq,
   input  logic                      ext_hold,
   input  logic                      flush_req,
   input  logic [PC_W-1:0]           flush_pc,
   output logic [NSTAGE-1:0]         stall,
   output logic                      flush,
   output logic                      new_pc_valid,
   output logic [PC_W-1:0]           new_pc,
   output logic [$clog2(NSTAGE)-1:0] stall_cause,
   output logic [PERF_W-1:0]         stall_cycles,
   output logic                      wdog_err
);

   localparam int CW   = $clog2(NSTAGE);
   localparam int FC_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

   localparam logic [FC_W-1:0] FC_LOAD   = FC_W'(FLUSH_HOLD - 1);
   localparam logic [CW-1:0]   CAUSE_EXT = CW'(NSTAGE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_REDIR
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [FC_W-1:0]   fcnt;
   logic [FC_W-1:0]   fcnt_nxt;
   logic              load_pc;

   logic [NSTAGE-1:0] req_eff;
   logic [CW-1:0]     req_hi;
   logic              req_any;

   logic [WDOG_W-1:0] wd_cnt;
   logic [WDOG_W-1:0] wd_nxt;

   // Stage requests are ignored while flushing and in the cycle a flush
   // is accepted: the flush wins and the pipe is about to be emptied.
   always_comb begin
      req_eff = stallreq;
      if (state == S_FLUSH || flush_req) begin
         req_eff = '0;
      end
   end

   always_comb begin
      req_hi  = '0;
      req_any = 1'b0;
      for (int i = 0; i < NSTAGE; i++) begin
         if (req_eff[i]) begin
            req_hi  = CW'(i);
            req_any = 1'b1;
         end
      end
   end

   // Stage i holds when any stage at or above i requests a hold, so the
   // stage just downstream of the highest requester gets a bubble.
   always_comb begin
      stall = '0;
      for (int i = 0; i < NSTAGE; i++) begin
         stall[i] = ext_hold | (|(req_eff >> i));
      end
   end

   assign flush = (state == S_FLUSH);

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      load_pc   = 1'b0;
      unique case (state)
         S_IDLE, S_REDIR: begin
            state_nxt = S_IDLE;
            if (flush_req) begin
               state_nxt = S_FLUSH;
               fcnt_nxt  = FC_LOAD;
               load_pc   = 1'b1;
            end
         end
         S_FLUSH: begin
            if (flush_req) begin
               fcnt_nxt = FC_LOAD;
               load_pc  = 1'b1;
            end else if (!ext_hold) begin
               if (fcnt == '0) begin
                  state_nxt = S_REDIR;
               end else begin
                  fcnt_nxt = fcnt - 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            fcnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         fcnt         <= '0;
         new_pc       <= '0;
         new_pc_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         fcnt         <= fcnt_nxt;
         new_pc_valid <= (state_nxt == S_REDIR);
         if (load_pc) begin
            new_pc <= flush_pc;
         end
      end
   end

   // A pure ext_hold stall is charged to the last stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cause <= '0;
      end else if (stall[0]) begin
         stall_cause <= req_any ? req_hi : CAUSE_EXT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (stall[0] && stall_cycles != '1) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

   // A flush cycle is progress, so it restarts the count even under hold.
   always_comb begin
      if (flush || !stall[0]) begin
         wd_nxt = '0;
      end else if (wd_cnt == WDOG_MAX) begin
         wd_nxt = wd_cnt;
      end else begin
         wd_nxt = wd_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt   <= '0;
         wdog_err <= 1'b0;
      end else begin
         wd_cnt <= wd_nxt;
         if (wd_nxt == WDOG_MAX) begin
            wdog_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// tb_pipe_stall_flush_ctrl: directed and random stimulus for
// pipe_stall_flush_ctrl, compared against a behavioural model every cycle.

module tb_pipe_stall_flush_ctrl;

   localparam int FH   = 2;
   localparam int WMAX = 8;
   localparam int PMAX = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stallreq = '0;
   logic        ext_hold = 1'b0;
   logic        flush_req = 1'b0;
   logic [31:0] flush_pc = '0;
   logic [5:0]  stall;
   logic        flush;
   logic        new_pc_valid;
   logic [31:0] new_pc;
   logic [2:0]  stall_cause;
   logic [2:0]  stall_cycles;
   logic        wdog_err;

   int checks = 0;
   int errors = 0;

   pipe_stall_flush_ctrl #(
      .NSTAGE(6),
      .PC_W(32),
      .FLUSH_HOLD(FH),
      .WDOG_W(4),
      .WDOG_MAX(4'd8),
      .PERF_W(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stallreq(stallreq),
      .ext_hold(ext_hold),
      .flush_req(flush_req),
      .flush_pc(flush_pc),
      .stall(stall),
      .flush(flush),
      .new_pc_valid(new_pc_valid),
      .new_pc(new_pc),
      .stall_cause(stall_cause),
      .stall_cycles(stall_cycles),
      .wdog_err(wdog_err)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h",
                  name, $time, act, exp);
      end
   endtask

   // Behavioural model: remaining flush cycles, pending redirect strobe,
   // plain integer counters.
   int          m_flush_left = 0;
   bit          m_redir = 0;
   logic [31:0] m_pc = '0;
   int          m_cause = 0;
   int          m_cyc = 0;
   int          m_wd = 0;
   bit          m_err = 0;

   logic [5:0]  m_eff;
   int          m_hi;
   int          m_tmp;
   logic [5:0]  m_stall;

   always_comb begin
      m_eff   = stallreq;
      m_hi    = -1;
      m_tmp   = 0;
      m_stall = '0;
      if (m_flush_left > 0 || flush_req) m_eff = '0;
      for (int i = 0; i < 6; i++) begin
         if (m_eff[i]) m_hi = i;
      end
      if (ext_hold) begin
         m_stall = 6'h3F;
      end else if (m_hi >= 0) begin
         m_tmp   = (1 << (m_hi + 1)) - 1;
         m_stall = m_tmp[5:0];
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_flush_left <= 0;
         m_redir      <= 0;
         m_pc         <= '0;
         m_cause      <= 0;
         m_cyc        <= 0;
         m_wd         <= 0;
         m_err        <= 0;
      end else begin
         if (m_stall[0]) m_cause <= (m_hi >= 0) ? m_hi : 5;
         if (m_stall[0] && m_cyc < PMAX) m_cyc <= m_cyc + 1;
         if (m_flush_left > 0 || !m_stall[0]) begin
            m_wd <= 0;
         end else if (m_wd < WMAX) begin
            m_wd <= m_wd + 1;
            if (m_wd + 1 == WMAX) m_err <= 1;
         end
         if (flush_req) begin
            m_pc         <= flush_pc;
            m_flush_left <= FH;
            m_redir      <= 0;
         end else if (m_flush_left > 0) begin
            m_redir <= 0;
            if (!ext_hold) begin
               m_flush_left <= m_flush_left - 1;
               if (m_flush_left == 1) m_redir <= 1;
            end
         end else begin
            m_redir <= 0;
         end
      end
   end

   always @(negedge clk) begin
      cmp("stall", 32'(stall), 32'(m_stall));
      cmp("flush", 32'(flush), 32'(m_flush_left > 0));
      cmp("new_pc_valid", 32'(new_pc_valid), 32'(m_redir));
      cmp("new_pc", new_pc, m_pc);
      cmp("stall_cause", 32'(stall_cause), 32'(m_cause));
      cmp("stall_cycles", 32'(stall_cycles), 32'(m_cyc));
      cmp("wdog_err", 32'(wdog_err), 32'(m_err));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) cyc();
      rst = 1'b0;
      @(negedge clk);
      cmp("lit_rst_stall", 32'(stall), 32'h0);
      cmp("lit_rst_flush", 32'(flush), 32'h0);
      cmp("lit_rst_cycles", 32'(stall_cycles), 32'h0);
      cmp("lit_rst_wdog", 32'(wdog_err), 32'h0);

      for (int i = 0; i < 3; i++) begin
         cyc();
         stallreq = 6'b000100;
         @(negedge clk);
         cmp("lit_req2_stall", 32'(stall), 32'h07);
      end
      cyc();
      stallreq = '0;
      @(negedge clk);
      cmp("lit_req2_cause", 32'(stall_cause), 32'd2);
      cmp("lit_req2_cycles", 32'(stall_cycles), 32'd3);
      cyc();
      stallreq = 6'b010100;
      @(negedge clk);
      cmp("lit_req4_stall", 32'(stall), 32'h1F);
      cyc();
      stallreq = '0;
      @(negedge clk);
      cmp("lit_req4_cause", 32'(stall_cause), 32'd4);

      cyc();
      flush_req = 1'b1;
      flush_pc  = 32'hBFC0_0380;
      @(negedge clk);
      cmp("lit_fl_t0", 32'(flush), 32'h0);
      cyc();
      flush_req = 1'b0;
      stallreq  = 6'b001000;
      @(negedge clk);
      cmp("lit_fl_t1", 32'(flush), 32'h1);
      cmp("lit_fl_t1_stall", 32'(stall), 32'h0);
      cyc();
      @(negedge clk);
      cmp("lit_fl_t2", 32'(flush), 32'h1);
      cmp("lit_fl_t2_stall", 32'(stall), 32'h0);
      cmp("lit_fl_t2_npv", 32'(new_pc_valid), 32'h0);
      cyc();
      stallreq = '0;
      @(negedge clk);
      cmp("lit_fl_t3", 32'(flush), 32'h0);
      cmp("lit_fl_t3_npv", 32'(new_pc_valid), 32'h1);
      cmp("lit_fl_t3_pc", new_pc, 32'hBFC0_0380);
      cyc();
      @(negedge clk);
      cmp("lit_fl_t4_npv", 32'(new_pc_valid), 32'h0);

      cyc();
      flush_req = 1'b1;
      flush_pc  = 32'h1234_5678;
      cyc();
      flush_req = 1'b0;
      ext_hold  = 1'b1;
      @(negedge clk);
      cmp("lit_eh_stall", 32'(stall), 32'h3F);
      cmp("lit_eh_flush", 32'(flush), 32'h1);
      cyc();
      ext_hold = 1'b0;
      @(negedge clk);
      cmp("lit_eh_t2", 32'(flush), 32'h1);
      cmp("lit_eh_cause", 32'(stall_cause), 32'd5);
      cyc();
      flush_req = 1'b1;
      flush_pc  = 32'h8000_0000;
      @(negedge clk);
      cmp("lit_eh_extra", 32'(flush), 32'h1);
      cmp("lit_eh_npv", 32'(new_pc_valid), 32'h0);
      cyc();
      flush_req = 1'b0;
      @(negedge clk);
      cmp("lit_rf_t1", 32'(flush), 32'h1);
      cmp("lit_rf_pc", new_pc, 32'h8000_0000);
      cyc();
      @(negedge clk);
      cmp("lit_rf_t2", 32'(flush), 32'h1);
      cmp("lit_rf_t2_npv", 32'(new_pc_valid), 32'h0);
      cyc();
      @(negedge clk);
      cmp("lit_rf_npv", 32'(new_pc_valid), 32'h1);
      cmp("lit_rf_npc", new_pc, 32'h8000_0000);

      for (int i = 0; i < 8; i++) begin
         cyc();
         stallreq = 6'b000010;
         @(negedge clk);
         cmp("lit_wd_pre", 32'(wdog_err), 32'h0);
      end
      cyc();
      stallreq = '0;
      @(negedge clk);
      cmp("lit_wd_set", 32'(wdog_err), 32'h1);
      repeat (3) cyc();
      @(negedge clk);
      cmp("lit_wd_sticky", 32'(wdog_err), 32'h1);
      cmp("lit_wd_sat_cycles", 32'(stall_cycles), 32'd7);
      cyc();
      #2 rst = 1'b1;
      @(negedge clk);
      cmp("lit_wd_rst", 32'(wdog_err), 32'h0);
      cmp("lit_wd_rst_cyc", 32'(stall_cycles), 32'h0);
      cyc();
      rst = 1'b0;

      cyc();
      flush_req = 1'b1;
      flush_pc  = 32'hDEAD_BEE0;
      cyc();
      flush_req = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      cmp("lit_mid_flush", 32'(flush), 32'h0);
      cmp("lit_mid_pc", new_pc, 32'h0);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         @(negedge clk);
         cmp("lit_mid_npv", 32'(new_pc_valid), 32'h0);
      end

      for (int i = 0; i < 10; i++) begin
         cyc();
         stallreq = 6'b000001;
      end
      cyc();
      stallreq = '0;
      @(negedge clk);
      cmp("lit_perf_sat", 32'(stall_cycles), 32'd7);
      cyc();
      @(negedge clk);
      cmp("lit_perf_hold", 32'(stall_cycles), 32'd7);

      for (int i = 0; i < 3000; i++) begin
         cyc();
         rst = 1'b0;
         if ($urandom_range(0, 2) == 0) stallreq = 6'($urandom);
         else stallreq = '0;
         ext_hold  = ($urandom_range(0, 5) == 0);
         flush_req = ($urandom_range(0, 7) == 0);
         flush_pc  = $urandom;
         if ($urandom_range(0, 149) == 0) #2 rst = 1'b1;
      end
      cyc();
      rst       = 1'b0;
      stallreq  = '0;
      ext_hold  = 1'b0;
      flush_req = 1'b0;
      repeat (4) cyc();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
